id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/id_ex_stage_if.sv | 41 ++++
 rtl/load_use_detect.sv | 22 ++
 rtl/id_ex_stage.sv | 117 +++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types and constants.
package cpu_pkg;

    localparam int unsigned DATA_W = 64;
    localparam logic [4:0]  XZR    = 5'd31;

    // Decoded control word, MSB first: RegWrite..ALUOp.
    typedef struct packed {
        logic       RegWrite;
        logic       MemRead;
        logic       MemWrite;
        logic       MemToReg;
        logic       ALUSrc;
        logic [2:0] ALUOp;
    } ctrl_t;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } stage_state_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bus: decode-side inputs, flush, stall and registered EX outputs.
interface id_ex_stage_if #(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W
);
    import cpu_pkg::*;

    logic              id_valid;
    logic [4:0]        id_Rn;
    logic [4:0]        id_Rm;
    logic [4:0]        id_Rd;
    logic              id_uses_Rm;
    logic [DATA_W-1:0] id_rdA;
    logic [DATA_W-1:0] id_rdB;
    logic [DATA_W-1:0] id_imm;
    ctrl_t             id_ctrl;
    logic              flush;
    logic              stall;
    logic              ex_valid;
    logic [4:0]        ex_Rn;
    logic [4:0]        ex_Rm;
    logic [4:0]        ex_Rd;
    logic [DATA_W-1:0] ex_rdA;
    logic [DATA_W-1:0] ex_rdB;
    logic [DATA_W-1:0] ex_imm;
    ctrl_t             ex_ctrl;

    modport master (
        output id_valid, id_Rn, id_Rm, id_Rd, id_uses_Rm,
               id_rdA, id_rdB, id_imm, id_ctrl, flush,
        input  stall, ex_valid, ex_Rn, ex_Rm, ex_Rd,
               ex_rdA, ex_rdB, ex_imm, ex_ctrl
    );

    modport slave (
        input  id_valid, id_Rn, id_Rm, id_Rd, id_uses_Rm,
               id_rdA, id_rdB, id_imm, id_ctrl, flush,
        output stall, ex_valid, ex_Rn, ex_Rm, ex_Rd,
               ex_rdA, ex_rdB, ex_imm, ex_ctrl
    );

endinterface

// File: rtl/load_use_detect.sv
// Raw load-use hazard: a valid load in EX writes a register the decode
// instruction reads. XZR is never a hazard source.
module load_use_detect #(
    parameter logic [4:0] XZR = cpu_pkg::XZR
) (
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_Rd_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_Rn_i,
    input  logic [4:0] id_Rm_i,
    input  logic       id_uses_Rm_i,
    output logic       hazard_o
);

    // Compare decode sources against the load destination in EX.
    always_comb begin
        hazard_o = ex_valid_i && ex_mem_read_i && (ex_Rd_i != XZR) && id_valid_i &&
                   ((id_Rn_i == ex_Rd_i) || (id_uses_Rm_i && (id_Rm_i == ex_Rd_i)));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with one-cycle load-use stall and flush.
// Optional STALL_CNT_EN adds a saturating stall_count output.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W,
    parameter logic [4:0]  XZR    = cpu_pkg::XZR
) (
    input  logic         clk,
    input  logic         reset,
    id_ex_stage_if.slave bus
`ifdef STALL_CNT_EN
    ,
    output logic [31:0]  stall_count
`endif
);

    stage_state_e      state_q, state_d;
    logic              hazard;
    logic              stall;
    logic              load_bubble;

    logic              ex_valid_q;
    logic [4:0]        ex_Rn_q, ex_Rm_q, ex_Rd_q;
    logic [DATA_W-1:0] ex_rdA_q, ex_rdB_q, ex_imm_q;
    ctrl_t             ex_ctrl_q;

    load_use_detect #(
        .XZR (XZR)
    ) u_detect (
        .ex_valid_i    (ex_valid_q),
        .ex_mem_read_i (ex_ctrl_q.MemRead),
        .ex_Rd_i       (ex_Rd_q),
        .id_valid_i    (bus.id_valid),
        .id_Rn_i       (bus.id_Rn),
        .id_Rm_i       (bus.id_Rm),
        .id_uses_Rm_i  (bus.id_uses_Rm),
        .hazard_o      (hazard)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    // FSM next state: a stall lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     state_d = stall ? BUBBLE : RUN;
            BUBBLE:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM outputs: flush and reset suppress stall; either stall or flush inserts a bubble.
    always_comb begin
        stall       = hazard && (state_q == RUN) && !bus.flush && !reset;
        load_bubble = stall || bus.flush;
    end

    // ID/EX pipeline register; invalid decode slots are captured with control cleared.
    always_ff @(posedge clk) begin
        if (reset || load_bubble) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_Rn_q    <= XZR;
            ex_Rm_q    <= XZR;
            ex_Rd_q    <= XZR;
            ex_rdA_q   <= '0;
            ex_rdB_q   <= '0;
            ex_imm_q   <= '0;
        end else begin
            ex_valid_q <= bus.id_valid;
            ex_ctrl_q  <= bus.id_valid ? bus.id_ctrl : '0;
            ex_Rn_q    <= bus.id_Rn;
            ex_Rm_q    <= bus.id_Rm;
            ex_Rd_q    <= bus.id_Rd;
            ex_rdA_q   <= bus.id_rdA;
            ex_rdB_q   <= bus.id_rdB;
            ex_imm_q   <= bus.id_imm;
        end
    end

    // Drive registered EX contents onto the bus.
    always_comb begin
        bus.stall    = stall;
        bus.ex_valid = ex_valid_q;
        bus.ex_ctrl  = ex_ctrl_q;
        bus.ex_Rn    = ex_Rn_q;
        bus.ex_Rm    = ex_Rm_q;
        bus.ex_Rd    = ex_Rd_q;
        bus.ex_rdA   = ex_rdA_q;
        bus.ex_rdB   = ex_rdB_q;
        bus.ex_imm   = ex_imm_q;
    end

`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating stall counter next value.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule
